// File: rtl/pll_mon_pkg.sv
// Shared types and default constants for the PLL lock monitor.
package pll_mon_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABILIZE = 2'd1,
    ST_RUN       = 2'd2,
    ST_ILLEGAL   = 2'd3
  } pll_state_e;

  localparam int PLL_MON_SYNC_STAGES   = 2;
  localparam int PLL_MON_STABLE_CYCLES = 1024;
  localparam int PLL_MON_CNT_W         = 8;

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchroniser, synchronously cleared to 0.
module sync_bit #(
  parameter int N = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_chain;

  // shift chain; i_d only ever lands in stage 0
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[N-2:0], i_d};
    end
  end

  assign o_q = r_chain[N-1];

endmodule

// File: rtl/pll_lock_monitor.sv
// Holds system reset until PLL lock has been stable long enough; tracks lock losses.
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int SYNC_STAGES   = PLL_MON_SYNC_STAGES,
  parameter int STABLE_CYCLES = PLL_MON_STABLE_CYCLES,
  parameter int CNT_W         = PLL_MON_CNT_W
) (
  input  logic             CLOCK_200,
  input  logic             reset,
  input  logic             locked,
  input  logic             clear_lost,
  output logic             sys_reset,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] loss_count,
  output logic [1:0]       state
);

  localparam int            CW       = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOSS_MAX = '1;

  logic             w_locked_s;
  pll_state_e       r_state;
  pll_state_e       w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic             w_loss_event;
  logic             r_sys_reset;
  logic             r_ready;
  logic             r_lock_lost;
  logic [CNT_W-1:0] r_loss_count;

  sync_bit #(.N(SYNC_STAGES)) u_sync_locked (
    .i_clk (CLOCK_200),
    .i_rst (reset),
    .i_d   (locked),
    .o_q   (w_locked_s)
  );

  // next-state and stability count; the WAIT->STABILIZE edge already counts as
  // one stable cycle so release lands exactly SYNC_STAGES+STABLE_CYCLES edges in
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_loss_event = 1'b0;
    case (r_state)
      ST_WAIT_LOCK: begin
        if (w_locked_s) begin
          w_next_state = ST_STABILIZE;
          w_cnt_next   = CW'(1'b1);
        end else begin
          w_cnt_next   = '0;
        end
      end
      ST_STABILIZE: begin
        if (!w_locked_s) begin
          w_next_state = ST_WAIT_LOCK;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state = ST_RUN;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + CW'(1'b1);
        end
      end
      ST_RUN: begin
        w_cnt_next = '0;
        if (!w_locked_s) begin
          w_next_state = ST_WAIT_LOCK;
          w_loss_event = 1'b1;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      default: begin
        w_next_state = ST_WAIT_LOCK;
        w_cnt_next   = '0;
      end
    endcase
  end

  // state, counter and registered outputs
  always_ff @(posedge CLOCK_200) begin
    if (reset) begin
      r_state      <= ST_WAIT_LOCK;
      r_cnt        <= '0;
      r_sys_reset  <= 1'b1;
      r_ready      <= 1'b0;
      r_lock_lost  <= 1'b0;
      r_loss_count <= '0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_cnt_next;
      r_sys_reset <= (w_next_state != ST_RUN);
      r_ready     <= (w_next_state == ST_RUN);
      // a loss on the same edge as clear_lost keeps the flag set
      if (w_loss_event) begin
        r_lock_lost <= 1'b1;
      end else if (clear_lost) begin
        r_lock_lost <= 1'b0;
      end else begin
        r_lock_lost <= r_lock_lost;
      end
      if (w_loss_event && (r_loss_count != LOSS_MAX)) begin
        r_loss_count <= r_loss_count + CNT_W'(1'b1);
      end else begin
        r_loss_count <= r_loss_count;
      end
    end
  end

  assign sys_reset  = r_sys_reset;
  assign ready      = r_ready;
  assign lock_lost  = r_lock_lost;
  assign loss_count = r_loss_count;
  assign state      = r_state;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor with STABLE_CYCLES=16, SYNC_STAGES=2, CNT_W=2.
module tb_pll_lock_monitor;

  logic       clk;
  logic       reset;
  logic       locked;
  logic       clear_lost;
  logic       sys_reset;
  logic       ready;
  logic       lock_lost;
  logic [1:0] loss_count;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  pll_lock_monitor #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (16),
    .CNT_W         (2)
  ) dut (
    .CLOCK_200  (clk),
    .reset      (reset),
    .locked     (locked),
    .clear_lost (clear_lost),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .loss_count (loss_count),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // advance n rising edges, leaving time 1 unit past the last one
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // from WAIT_LOCK with an empty sync chain: release takes exactly 18 edges
  task automatic lock_up(input string tag);
    locked = 1'b1;
    step(17);
    check_eq({tag, "_ready_early"}, {31'd0, ready}, 32'd0);
    step(1);
    check_eq({tag, "_ready"}, {31'd0, ready}, 32'd1);
    check_eq({tag, "_sysrst"}, {31'd0, sys_reset}, 32'd0);
    check_eq({tag, "_state"}, {30'd0, state}, 32'd2);
  endtask

  // drop locked in RUN: sys_reset reasserts on the third edge
  task automatic lose(input string tag, input logic [1:0] exp_cnt);
    locked = 1'b0;
    step(2);
    check_eq({tag, "_sysrst_early"}, {31'd0, sys_reset}, 32'd0);
    step(1);
    check_eq({tag, "_sysrst"}, {31'd0, sys_reset}, 32'd1);
    check_eq({tag, "_ready"}, {31'd0, ready}, 32'd0);
    check_eq({tag, "_lost"}, {31'd0, lock_lost}, 32'd1);
    check_eq({tag, "_cnt"}, {30'd0, loss_count}, {30'd0, exp_cnt});
  endtask

  initial begin
    reset      = 1'b1;
    locked     = 1'b0;
    clear_lost = 1'b0;

    // power-up
    step(4);
    check_eq("pwr_sysrst", {31'd0, sys_reset}, 32'd1);
    check_eq("pwr_ready", {31'd0, ready}, 32'd0);
    check_eq("pwr_state", {30'd0, state}, 32'd0);
    check_eq("pwr_cnt", {30'd0, loss_count}, 32'd0);
    check_eq("pwr_lost", {31'd0, lock_lost}, 32'd0);
    reset = 1'b0;
    step(3);
    check_eq("hold_sysrst", {31'd0, sys_reset}, 32'd1);
    check_eq("hold_state", {30'd0, state}, 32'd0);

    // clean lock, then a loss in RUN and relock
    lock_up("clean");
    lose("loss1", 2'd1);
    lock_up("relock1");
    check_eq("relock1_lost", {31'd0, lock_lost}, 32'd1);

    // saturation of the loss counter
    lose("loss2", 2'd2);
    lock_up("relock2");
    lose("loss3", 2'd3);
    lock_up("relock3");
    lose("loss4", 2'd3);
    clear_lost = 1'b1;
    step(1);
    clear_lost = 1'b0;
    check_eq("clear_alone1", {31'd0, lock_lost}, 32'd0);
    lock_up("relock4");

    // clear_lost coinciding with the loss edge: the set wins
    locked = 1'b0;
    step(2);
    clear_lost = 1'b1;
    step(1);
    clear_lost = 1'b0;
    check_eq("clr_vs_loss_lost", {31'd0, lock_lost}, 32'd1);
    check_eq("clr_vs_loss_cnt", {30'd0, loss_count}, 32'd3);
    check_eq("clr_vs_loss_sysrst", {31'd0, sys_reset}, 32'd1);
    clear_lost = 1'b1;
    step(1);
    clear_lost = 1'b0;
    check_eq("clear_alone2", {31'd0, lock_lost}, 32'd0);

    // reset mid-RUN with loss_count=2
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_eq("rst_cnt_zero", {30'd0, loss_count}, 32'd0);
    lock_up("r_lock_a");
    lose("r_loss_a", 2'd1);
    lock_up("r_lock_b");
    lose("r_loss_b", 2'd2);
    lock_up("r_lock_c");
    check_eq("pre_rst_cnt", {30'd0, loss_count}, 32'd2);
    reset  = 1'b1;
    locked = 1'b0;
    step(1);
    check_eq("midrst_sysrst", {31'd0, sys_reset}, 32'd1);
    check_eq("midrst_ready", {31'd0, ready}, 32'd0);
    check_eq("midrst_cnt", {30'd0, loss_count}, 32'd0);
    check_eq("midrst_lost", {31'd0, lock_lost}, 32'd0);
    check_eq("midrst_state", {30'd0, state}, 32'd0);
    reset = 1'b0;
    step(2);

    // one-cycle glitch while the stability count is 10
    locked = 1'b1;
    step(10);
    check_eq("gl_state_stab", {30'd0, state}, 32'd1);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(1);
    check_eq("gl_state_still_stab", {30'd0, state}, 32'd1);
    step(1);
    check_eq("gl_state_wait", {30'd0, state}, 32'd0);
    check_eq("gl_cnt", {30'd0, loss_count}, 32'd0);
    check_eq("gl_lost", {31'd0, lock_lost}, 32'd0);
    step(15);
    check_eq("gl_ready_early", {31'd0, ready}, 32'd0);
    step(1);
    check_eq("gl_ready", {31'd0, ready}, 32'd1);
    check_eq("gl_sysrst", {31'd0, sys_reset}, 32'd0);
    check_eq("gl_cnt_end", {30'd0, loss_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
